// File: rtl/wb_queue.sv
// Writeback queue: merges load and ALU results into an in-order FIFO that drains
// one register-file write per clock and exposes pending-write lookups for decode.
// Optional build macro WB_BYPASS_EN enables forwarding of the youngest queued data.
module wb_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned DW    = 32,
    parameter int unsigned AW    = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     mem_valid,
    input  logic [AW-1:0]            mem_reg,
    input  logic [DW-1:0]            mem_data,
    output logic                     mem_ready,
    input  logic                     alu_valid,
    input  logic [AW-1:0]            alu_reg,
    input  logic [DW-1:0]            alu_data,
    output logic                     alu_ready,
    output logic                     write,
    output logic [AW-1:0]            write_reg,
    output logic [DW-1:0]            write_data,
    input  logic [AW-1:0]            q_reg1,
    input  logic [AW-1:0]            q_reg2,
    output logic                     hazard1,
    output logic                     hazard2,
    output logic                     fwd_valid1,
    output logic [DW-1:0]            fwd_data1,
    output logic                     fwd_valid2,
    output logic [DW-1:0]            fwd_data2,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count_q;
    logic [AW-1:0] reg_q  [DEPTH];
    logic [DW-1:0] data_q [DEPTH];

    logic          mem_push;
    logic          alu_push;
    logic          pop;
    logic [PW-1:0] alu_slot;
    logic [PW-1:0] wr_ptr_next;
    logic [PW-1:0] rd_ptr_next;
    logic [CW-1:0] count_next;

    // Ready looks only at current occupancy; a same-cycle pop is not credited.
    assign mem_ready = rst && (count_q <= CW'(DEPTH - 1));
    assign alu_ready = rst && (({1'b0, count_q} + (CW + 1)'(mem_valid)) <= (CW + 1)'(DEPTH - 1));

    assign mem_push = mem_valid && mem_ready;
    assign alu_push = alu_valid && alu_ready;
    assign pop      = (count_q != '0);

    // The load result is older than a simultaneous ALU result.
    assign alu_slot    = wr_ptr + PW'(mem_push);
    assign wr_ptr_next = wr_ptr + PW'(mem_push) + PW'(alu_push);
    assign rd_ptr_next = rd_ptr + PW'(pop);
    assign count_next  = count_q + CW'(mem_push) + CW'(alu_push) - CW'(pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else begin
            rd_ptr  <= rd_ptr_next;
            wr_ptr  <= wr_ptr_next;
            count_q <= count_next;
        end
    end

    // Entry storage carries no reset; occupancy is tracked by count_q alone.
    always_ff @(posedge clk) begin
        if (mem_push) begin
            reg_q[wr_ptr]  <= mem_reg;
            data_q[wr_ptr] <= mem_data;
        end
        if (alu_push) begin
            reg_q[alu_slot]  <= alu_reg;
            data_q[alu_slot] <= alu_data;
        end
    end

    assign count      = count_q;
    assign write      = pop;
    assign write_reg  = reg_q[rd_ptr];
    assign write_data = data_q[rd_ptr];

    // Lookup walks entries by age offset from the head: offset 0 is oldest.
    logic [PW-1:0]    idx_off [DEPTH];
    logic [DEPTH-1:0] occ_off;
    logic [DEPTH-1:0] match1;
    logic [DEPTH-1:0] match2;

    for (genvar k = 0; k < DEPTH; k++) begin : g_lookup
        assign idx_off[k] = rd_ptr + PW'(k);
        assign occ_off[k] = (CW'(k) < count_q);
        assign match1[k]  = occ_off[k] && (reg_q[idx_off[k]] == q_reg1);
        assign match2[k]  = occ_off[k] && (reg_q[idx_off[k]] == q_reg2);
    end

    assign hazard1 = |match1;
    assign hazard2 = |match2;

`ifdef WB_BYPASS_EN
    // Later offsets overwrite earlier ones, so the youngest match wins.
    always_comb begin
        fwd_data1 = '0;
        fwd_data2 = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            if (match1[k]) fwd_data1 = data_q[idx_off[k]];
            if (match2[k]) fwd_data2 = data_q[idx_off[k]];
        end
    end

    assign fwd_valid1 = hazard1;
    assign fwd_valid2 = hazard2;
`else
    assign fwd_valid1 = 1'b0;
    assign fwd_valid2 = 1'b0;
    assign fwd_data1  = '0;
    assign fwd_data2  = '0;
`endif

endmodule

// File: tb/tb_wb_queue.sv
// Directed bench for wb_queue: reset, ordering, backpressure, wrap and mid-run reset.
module tb_wb_queue;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned DW    = 32;
    localparam int unsigned AW    = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          mem_valid;
    logic [AW-1:0] mem_reg;
    logic [DW-1:0] mem_data;
    logic          mem_ready;
    logic          alu_valid;
    logic [AW-1:0] alu_reg;
    logic [DW-1:0] alu_data;
    logic          alu_ready;
    logic          write;
    logic [AW-1:0] write_reg;
    logic [DW-1:0] write_data;
    logic [AW-1:0] q_reg1;
    logic [AW-1:0] q_reg2;
    logic          hazard1;
    logic          hazard2;
    logic          fwd_valid1;
    logic [DW-1:0] fwd_data1;
    logic          fwd_valid2;
    logic [DW-1:0] fwd_data2;
    logic [2:0]    count;

    int checks = 0;
    int errors = 0;

    wb_queue #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .mem_valid  (mem_valid),
        .mem_reg    (mem_reg),
        .mem_data   (mem_data),
        .mem_ready  (mem_ready),
        .alu_valid  (alu_valid),
        .alu_reg    (alu_reg),
        .alu_data   (alu_data),
        .alu_ready  (alu_ready),
        .write      (write),
        .write_reg  (write_reg),
        .write_data (write_data),
        .q_reg1     (q_reg1),
        .q_reg2     (q_reg2),
        .hazard1    (hazard1),
        .hazard2    (hazard2),
        .fwd_valid1 (fwd_valid1),
        .fwd_data1  (fwd_data1),
        .fwd_valid2 (fwd_valid2),
        .fwd_data2  (fwd_data2),
        .count      (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Forwarding expectations collapse to zero when the bypass is not built.
    task automatic check_fwd1(input string tag, input logic v, input logic [31:0] d);
`ifdef WB_BYPASS_EN
        check({tag, "_v1"}, 32'(fwd_valid1), 32'(v));
        check({tag, "_d1"}, fwd_data1, d);
`else
        check({tag, "_v1"}, 32'(fwd_valid1), 32'(1'b0 & v));
        check({tag, "_d1"}, fwd_data1, 32'h0 & d);
`endif
    endtask

    task automatic check_fwd2(input string tag, input logic v, input logic [31:0] d);
`ifdef WB_BYPASS_EN
        check({tag, "_v2"}, 32'(fwd_valid2), 32'(v));
        check({tag, "_d2"}, fwd_data2, d);
`else
        check({tag, "_v2"}, 32'(fwd_valid2), 32'(1'b0 & v));
        check({tag, "_d2"}, fwd_data2, 32'h0 & d);
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_mem(input logic [AW-1:0] r, input logic [DW-1:0] d);
        mem_valid = 1'b1;
        mem_reg   = r;
        mem_data  = d;
    endtask

    task automatic push_alu(input logic [AW-1:0] r, input logic [DW-1:0] d);
        alu_valid = 1'b1;
        alu_reg   = r;
        alu_data  = d;
    endtask

    task automatic idle();
        mem_valid = 1'b0;
        alu_valid = 1'b0;
    endtask

    initial begin
        // Reset held with both sources requesting
        rst    = 1'b0;
        q_reg1 = '0;
        q_reg2 = '0;
        push_mem(5'd1, 32'h1111);
        push_alu(5'd2, 32'h2222);
        tick();
        tick();
        check("rst_write", 32'(write), 32'd0);
        check("rst_mem_ready", 32'(mem_ready), 32'd0);
        check("rst_alu_ready", 32'(alu_ready), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_hazard1", 32'(hazard1), 32'd0);
        check_fwd1("rst", 1'b0, 32'h0);

        idle();
        rst = 1'b1;
        #1;
        check("rel_count", 32'(count), 32'd0);
        check("rel_write", 32'(write), 32'd0);

        // Single ALU push
        tick();
        push_alu(5'd5, 32'h0000_00AA);
        #1;
        check("single_alu_ready", 32'(alu_ready), 32'd1);
        tick();
        idle();
        #1;
        check("single_write", 32'(write), 32'd1);
        check("single_reg", 32'(write_reg), 32'd5);
        check("single_data", write_data, 32'hAA);
        check("single_count", 32'(count), 32'd1);
        tick();
        check("single_drained", 32'(count), 32'd0);
        check("single_write_off", 32'(write), 32'd0);

        // Dual push: mem entry is older
        push_mem(5'd3, 32'h11);
        push_alu(5'd3, 32'h22);
        q_reg1 = 5'd3;
        q_reg2 = 5'd7;
        #1;
        check("dual_mem_ready", 32'(mem_ready), 32'd1);
        check("dual_alu_ready", 32'(alu_ready), 32'd1);
        check("dual_no_input_hazard", 32'(hazard1), 32'd0);
        tick();
        idle();
        #1;
        check("dual_count", 32'(count), 32'd2);
        check("dual_w1", 32'(write), 32'd1);
        check("dual_w1_reg", 32'(write_reg), 32'd3);
        check("dual_w1_data", write_data, 32'h11);
        check("dual_hazard1", 32'(hazard1), 32'd1);
        check("dual_hazard2", 32'(hazard2), 32'd0);
        check_fwd1("dual_a", 1'b1, 32'h22);
        tick();
        check("dual_w2_reg", 32'(write_reg), 32'd3);
        check("dual_w2_data", write_data, 32'h22);
        check("dual_count2", 32'(count), 32'd1);
        check("dual_hazard1_b", 32'(hazard1), 32'd1);
        check_fwd1("dual_b", 1'b1, 32'h22);
        tick();
        check("dual_empty", 32'(count), 32'd0);
        check("dual_hazard_clear", 32'(hazard1), 32'd0);
        check_fwd1("dual_c", 1'b0, 32'h0);

        // Register 0 is ordinary
        push_alu(5'd0, 32'h5A);
        q_reg2 = 5'd0;
        tick();
        idle();
        #1;
        check("r0_reg", 32'(write_reg), 32'd0);
        check("r0_data", write_data, 32'h5A);
        check("r0_hazard2", 32'(hazard2), 32'd1);
        check_fwd2("r0", 1'b1, 32'h5A);
        tick();
        check("r0_drained", 32'(count), 32'd0);

        // Backpressure with three queued entries
        push_mem(5'd10, 32'hA0);
        push_alu(5'd11, 32'hA1);
        tick();
        push_mem(5'd12, 32'hA2);
        push_alu(5'd13, 32'hA3);
        #1;
        check("bp_pre_alu_ready", 32'(alu_ready), 32'd1);
        tick();
        push_mem(5'd14, 32'hA4);
        push_alu(5'd15, 32'hA5);
        #1;
        check("bp_count3", 32'(count), 32'd3);
        check("bp_head11", 32'(write_reg), 32'd11);
        check("bp_mem_ready", 32'(mem_ready), 32'd1);
        check("bp_alu_ready", 32'(alu_ready), 32'd0);
        tick();
        mem_valid = 1'b0;
        #1;
        check("bp_count_c", 32'(count), 32'd3);
        check("bp_head12", 32'(write_reg), 32'd12);
        check("bp_alu_ready_c", 32'(alu_ready), 32'd1);
        tick();
        idle();
        #1;
        check("bp_count_d", 32'(count), 32'd3);
        check("bp_head13", 32'(write_reg), 32'd13);
        check("bp_data13", write_data, 32'hA3);
        tick();
        check("bp_head14", 32'(write_reg), 32'd14);
        check("bp_data14", write_data, 32'hA4);
        check("bp_count_e", 32'(count), 32'd2);
        tick();
        check("bp_head15", 32'(write_reg), 32'd15);
        check("bp_data15", write_data, 32'hA5);
        check("bp_count_f", 32'(count), 32'd1);
        tick();
        check("bp_empty", 32'(count), 32'd0);

        // Streaming wrap-around
        for (int i = 1; i <= 10; i++) begin
            push_alu(AW'(i), 32'(i));
            #1;
            check("wrap_ready", 32'(alu_ready), 32'd1);
            tick();
            check("wrap_reg", 32'(write_reg), 32'(i));
            check("wrap_data", write_data, 32'(i));
            check("wrap_count", 32'(count), 32'd1);
        end
        idle();
        tick();
        check("wrap_empty", 32'(count), 32'd0);

        // Reset pulse between edges discards queued writes
        push_mem(5'd20, 32'hB0);
        push_alu(5'd21, 32'hB1);
        tick();
        push_mem(5'd22, 32'hB2);
        push_alu(5'd23, 32'hB3);
        tick();
        idle();
        q_reg1 = 5'd22;
        #1;
        check("mr_count", 32'(count), 32'd3);
        check("mr_head", 32'(write_reg), 32'd21);
        check("mr_hazard1", 32'(hazard1), 32'd1);
        check_fwd1("mr_pre", 1'b1, 32'hB2);
        #1;
        rst = 1'b0;
        #1;
        check("mr_write_drop", 32'(write), 32'd0);
        check("mr_hazard_drop", 32'(hazard1), 32'd0);
        check("mr_count_drop", 32'(count), 32'd0);
        check("mr_mem_ready", 32'(mem_ready), 32'd0);
        check_fwd1("mr_in", 1'b0, 32'h0);
        #1;
        rst = 1'b1;
        #1;
        check("mr_rel_count", 32'(count), 32'd0);
        check("mr_rel_alu_ready", 32'(alu_ready), 32'd1);
        tick();
        check("mr_after1_write", 32'(write), 32'd0);
        check("mr_after1_count", 32'(count), 32'd0);
        tick();
        check("mr_after2_write", 32'(write), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
